// File: rtl/pc16_stack_pkg.sv
// Shared defaults and control-priority encoding for the pc16_stack program counter.
package pc16_stack_pkg;

    localparam int unsigned PC_WIDTH = 16;
    localparam int unsigned PC_DEPTH = 4;

    // Per-edge operation, listed from highest to lowest priority
    typedef enum logic [2:0] {
        OP_RESET = 3'd0,
        OP_LOAD  = 3'd1,
        OP_POP   = 3'd2,
        OP_INC   = 3'd3,
        OP_HOLD  = 3'd4
    } op_e;

    function automatic op_e op_select(input logic reset, input logic load,
                                      input logic pop, input logic inc);
        if (reset)     return OP_RESET;
        else if (load) return OP_LOAD;
        else if (pop)  return OP_POP;
        else if (inc)  return OP_INC;
        else           return OP_HOLD;
    endfunction

endpackage

// File: rtl/pc16_stack_lifo_ram.sv
// Return-address storage: synchronous write, combinational read.
// Holds no pointer state; the caller supplies both addresses.
module pc16_stack_lifo_ram #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata_c
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/pc16_stack.sv
// 16-bit program counter with a hardware return-address stack (call/return).
// Define PC16_STACK_ERR_EN to add the sticky `err` output (push-while-full / pop-while-empty).
module pc16_stack
    import pc16_stack_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH,
    parameter int unsigned DEPTH = PC_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             push,
    input  logic             pop,
    input  logic             inc,
    output logic [WIDTH-1:0] out,
    output logic             empty,
`ifdef PC16_STACK_ERR_EN
    output logic             err,
`endif
    output logic             full
);

    localparam int unsigned SPW = $clog2(DEPTH + 1);
    localparam int unsigned AW  = $clog2(DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic [SPW-1:0]   r_occ;
    logic             r_empty;
    logic             r_full;

    op_e              w_op;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_pc_plus1;
    logic [SPW-1:0]   w_occ_next;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [AW-1:0]    w_raddr;
    logic [WIDTH-1:0] w_rdata;

    assign w_op       = op_select(reset, load, pop, inc);
    assign w_pc_plus1 = r_pc + WIDTH'(1);
    assign w_waddr    = AW'(r_occ);
    assign w_raddr    = AW'(r_occ - SPW'(1));

    pc16_stack_lifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_pc_plus1),
        .i_raddr   (w_raddr),
        .o_rdata_c (w_rdata)
    );

    // Next PC / occupancy selection
    always_comb begin
        w_pc_next  = r_pc;
        w_occ_next = r_occ;
        w_we       = 1'b0;
        case (w_op)
            OP_RESET: begin
            end
            OP_LOAD: begin
                w_pc_next = in;
                if (push && !r_full) begin
                    w_we       = 1'b1;
                    w_occ_next = r_occ + SPW'(1);
                end
            end
            OP_POP: begin
                if (!r_empty) begin
                    w_pc_next  = w_rdata;
                    w_occ_next = r_occ - SPW'(1);
                end
            end
            OP_INC: begin
                w_pc_next = w_pc_plus1;
            end
            OP_HOLD: begin
            end
            default: begin
            end
        endcase
    end

    // Flags are registered alongside occupancy so they always reflect it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= '0;
            r_occ   <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            r_pc    <= w_pc_next;
            r_occ   <= w_occ_next;
            r_empty <= (w_occ_next == SPW'(0));
            r_full  <= (w_occ_next == SPW'(DEPTH));
        end
    end

    assign out   = r_pc;
    assign empty = r_empty;
    assign full  = r_full;

`ifdef PC16_STACK_ERR_EN
    logic r_err;
    logic w_err_set;

    assign w_err_set = ((w_op == OP_LOAD) && push && r_full) ||
                       ((w_op == OP_POP) && r_empty);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_pc16_stack.sv
// Self-checking bench for pc16_stack: vector table plus scoreboard-checked call/return sequences.
module tb_pc16_stack;

    logic        clk = 1'b0;
    logic        reset, load, push, pop, inc;
    logic [15:0] in;
    logic [15:0] out;
    logic        empty, full;
`ifdef PC16_STACK_ERR_EN
    logic        err;
`endif

    always #5 clk = ~clk;

    pc16_stack dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .load  (load),
        .push  (push),
        .pop   (pop),
        .inc   (inc),
        .out   (out),
        .empty (empty),
`ifdef PC16_STACK_ERR_EN
        .err   (err),
`endif
        .full  (full)
    );

    typedef struct {
        logic        rst, ld, psh, pp, ic;
        logic [15:0] din;
        logic [15:0] eo;
        logic        ee, ef, er;
        string       name;
    } vec_t;

    typedef struct {
        logic [15:0] eo;
        logic        ee, ef, er;
        string       name;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    vec_t tbl[$];
    int   edge_cnt = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) edge_cnt++;

    // Scoreboard: compare each expectation once its edge has occurred
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
            logic ok;
            cur = exp_q.pop_front();
            ok = (out === cur.eo) && (empty === cur.ee) && (full === cur.ef);
`ifdef PC16_STACK_ERR_EN
            ok = ok && (err === cur.er);
`endif
            total++;
            if (!ok) begin
                bad++;
`ifdef PC16_STACK_ERR_EN
                $display("FAIL %s: got out=%h empty=%b full=%b err=%b, want out=%h empty=%b full=%b err=%b",
                         cur.name, out, empty, full, err, cur.eo, cur.ee, cur.ef, cur.er);
`else
                $display("FAIL %s: got out=%h empty=%b full=%b, want out=%h empty=%b full=%b",
                         cur.name, out, empty, full, cur.eo, cur.ee, cur.ef);
`endif
            end
        end
    end

    function automatic vec_t mk(input logic rst, ld, psh, pp, ic, input logic [15:0] din,
                                input logic [15:0] eo, input logic ee, ef, er, input string name);
        vec_t v;
        v.rst = rst; v.ld = ld; v.psh = psh; v.pp = pp; v.ic = ic; v.din = din;
        v.eo = eo; v.ee = ee; v.ef = ef; v.er = er; v.name = name;
        return v;
    endfunction

    task automatic step(input vec_t v);
        exp_t e;
        reset = v.rst; load = v.ld; push = v.psh; pop = v.pp; inc = v.ic; in = v.din;
        e.eo = v.eo; e.ee = v.ee; e.ef = v.ef; e.er = v.er; e.name = v.name;
        e.due = edge_cnt + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ret [4];
        logic [15:0] pc_m;
        logic [15:0] tgt;
        int          guard;

        reset = 1'b1; load = 1'b0; push = 1'b0; pop = 1'b0; inc = 1'b0; in = '0;

        //          rst ld psh pp ic  in        out       e  f  err
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, "reset"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0, "inc1"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0002, 1, 0, 0, "inc2"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0003, 1, 0, 0, "inc3"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0010, 16'h0010, 1, 0, 0, "jump_0010"));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h1234, 16'h1234, 0, 0, 0, "call_1234"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0011, 1, 0, 0, "ret_b2b"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0100, 16'h0100, 1, 0, 0, "jump_0100"));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0200, 16'h0200, 0, 0, 0, "call_0200"));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0300, 16'h0300, 0, 0, 0, "call_0300"));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0400, 16'h0400, 0, 0, 0, "call_0400"));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0500, 16'h0500, 0, 1, 0, "call_full"));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0500, 16'h0500, 0, 1, 1, "call_over"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0401, 0, 0, 1, "pop_0401"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0301, 0, 0, 1, "pop_0301"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0201, 0, 0, 1, "pop_0201"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0101, 1, 0, 1, "pop_0101"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 1, 0, 1, "jump_ffff"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 1, 0, 1, "inc_wrap"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 1, 0, 1, "jump_ffff2"));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0042, 16'h0042, 0, 0, 1, "call_from_ffff"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 1, 0, 1, "ret_wrap"));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, "reset2"));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0050, 16'h0050, 0, 0, 0, "call_0050"));
        tbl.push_back(mk(0, 1, 0, 1, 1, 16'h00AA, 16'h00AA, 0, 0, 0, "load_pop_inc"));
        tbl.push_back(mk(0, 0, 1, 0, 1, 16'h0000, 16'h00AB, 0, 0, 0, "push_no_load"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0001, 1, 0, 0, "pop_0001"));
        tbl.push_back(mk(0, 0, 0, 1, 1, 16'h0000, 16'h0001, 1, 0, 1, "pop_empty"));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0100, 16'h0100, 0, 0, 1, "call_a"));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0200, 16'h0200, 0, 0, 1, "call_b"));
        tbl.push_back(mk(1, 1, 1, 1, 1, 16'h1234, 16'h0000, 1, 0, 0, "reset_mid"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 1, 0, 1, "pop_after_rst"));

        foreach (tbl[i]) step(tbl[i]);

        // Random call chain unwound by pops; returns tracked by a small bench model
        step(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, "reset3"));
        step(mk(0, 1, 0, 0, 0, 16'h2000, 16'h2000, 1, 0, 0, "jump_2000"));
        pc_m = 16'h2000;
        for (int i = 0; i < 4; i++) begin
            tgt = 16'($urandom_range(0, 16'hFFFF));
            ret[i] = pc_m + 16'd1;
            pc_m = tgt;
            step(mk(0, 1, 1, 0, 0, tgt, tgt, 0, (i == 3), 0, "rnd_call"));
        end
        for (int i = 3; i >= 0; i--) begin
            step(mk(0, 0, 0, 1, 0, 16'h0000, ret[i], (i == 0), 0, 0, "rnd_ret"));
        end

        load = 1'b0; push = 1'b0; pop = 1'b0; inc = 1'b0; reset = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
